// File: rtl/two_reg_fifo.sv
// Two-entry register FIFO (head/tail shift, first-word fall-through) for ring-node skid buffering.
// Optional sticky overflow/underflow flags oOvf/oUdf are enabled by defining TWO_REG_FIFO_ERR_EN.
module two_reg_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iWrEn,
  input  logic [WIDTH-1:0] iWrDat,
  input  logic             iRdEn,
  output logic             oFul,
  output logic             oEmpty,
  output logic [1:0]       oDatVld,
  output logic [WIDTH-1:0] oRdDat
`ifdef TWO_REG_FIFO_ERR_EN
  ,
  output logic             oOvf,
  output logic             oUdf
`endif
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  // vld_q[0] = head valid, vld_q[1] = tail valid; thermometer coded, 10 unreachable
  logic [1:0]       vld_q, vld_d;
  logic             wr, rd;

  assign wr = iWrEn & ~vld_q[1];
  assign rd = iRdEn & vld_q[0];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    case (vld_q)
      2'b00: begin
        if (wr) begin
          head_d = iWrDat;
          vld_d  = 2'b01;
        end
      end
      2'b01: begin
        if (wr && rd) begin
          head_d = iWrDat;
        end else if (wr) begin
          tail_d = iWrDat;
          vld_d  = 2'b11;
        end else if (rd) begin
          vld_d  = 2'b00;
        end
      end
      2'b11: begin
        // a write is never accepted here, so only the pop matters
        if (rd) begin
          head_d = tail_q;
          vld_d  = 2'b01;
        end
      end
      default: vld_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= 2'b00;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  assign oDatVld = vld_q;
  assign oFul    = vld_q[1];
  assign oEmpty  = ~vld_q[0];
  assign oRdDat  = vld_q[0] ? head_q : '0;

`ifdef TWO_REG_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (iWrEn && vld_q[1]) ovf_q <= 1'b1;
      if (iRdEn && !vld_q[0]) udf_q <= 1'b1;
    end
  end

  assign oOvf = ovf_q;
  assign oUdf = udf_q;
`endif

endmodule

// File: tb/tb_two_reg_fifo.sv
// Self-checking bench for two_reg_fifo (WIDTH=8): directed vector table, reset corner, random scoreboard run.
module tb_two_reg_fifo;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         iWrEn;
  logic [W-1:0] iWrDat;
  logic         iRdEn;
  logic         oFul;
  logic         oEmpty;
  logic [1:0]   oDatVld;
  logic [W-1:0] oRdDat;
`ifdef TWO_REG_FIFO_ERR_EN
  logic         oOvf;
  logic         oUdf;
`endif

  two_reg_fifo #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .iWrEn   (iWrEn),
    .iWrDat  (iWrDat),
    .iRdEn   (iRdEn),
    .oFul    (oFul),
    .oEmpty  (oEmpty),
    .oDatVld (oDatVld),
    .oRdDat  (oRdDat)
`ifdef TWO_REG_FIFO_ERR_EN
    ,
    .oOvf    (oOvf),
    .oUdf    (oUdf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         wr;
    logic [W-1:0] dat;
    logic         rd;
    logic [1:0]   exp_vld;
    logic [W-1:0] exp_dat;
  } vec_t;

  vec_t         vecs [16];
  logic [W-1:0] sb_q [$];
  int           errors = 0;
  int           checks = 0;
  logic         exp_ovf = 1'b0;
  logic         exp_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] occ_mask(input int n);
    return (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
  endfunction

  task automatic check_status(input string tag, input logic [1:0] ev, input logic [W-1:0] ed);
    chk({tag, ".vld"}, {30'd0, oDatVld}, {30'd0, ev});
    chk({tag, ".ful"}, {31'd0, oFul}, {31'd0, ev == 2'b11});
    chk({tag, ".empty"}, {31'd0, oEmpty}, {31'd0, ev == 2'b00});
    chk({tag, ".rdat"}, {24'd0, oRdDat}, {24'd0, ed});
`ifdef TWO_REG_FIFO_ERR_EN
    chk({tag, ".ovf"}, {31'd0, oOvf}, {31'd0, exp_ovf});
    chk({tag, ".udf"}, {31'd0, oUdf}, {31'd0, exp_udf});
`endif
  endtask

  // Called at the negedge with inputs already driven: updates the scoreboard for the coming edge.
  task automatic model_step(input string tag);
    logic wr_acc, rd_acc;
    logic [W-1:0] popped;
    wr_acc = iWrEn && (sb_q.size() < 2);
    rd_acc = iRdEn && (sb_q.size() > 0);
    if (iWrEn && sb_q.size() == 2) exp_ovf = 1'b1;
    if (iRdEn && sb_q.size() == 0) exp_udf = 1'b1;
    if (rd_acc) begin
      popped = sb_q.pop_front();
      chk({tag, ".pop"}, {24'd0, oRdDat}, {24'd0, popped});
    end
    if (wr_acc) sb_q.push_back(iWrDat);
  endtask

  task automatic drive(input logic wr, input logic [W-1:0] dat, input logic rd);
    iWrEn  = wr;
    iWrDat = dat;
    iRdEn  = rd;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 2'b01, 8'h01};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 2'b11, 8'h01};
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 2'b11, 8'h01};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 2'b01, 8'h02};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[9]  = '{1'b1, 8'h05, 1'b0, 2'b01, 8'h05};
    vecs[10] = '{1'b1, 8'h06, 1'b1, 2'b01, 8'h06};
    vecs[11] = '{1'b1, 8'h07, 1'b0, 2'b11, 8'h06};
    vecs[12] = '{1'b1, 8'h09, 1'b1, 2'b01, 8'h07};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h00};
    vecs[14] = '{1'b1, 8'h0A, 1'b1, 2'b01, 8'h0A};
    vecs[15] = '{1'b1, 8'h0B, 1'b0, 2'b11, 8'h0A};

    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check_status("reset", 2'b00, 8'h00);
    $display("reset: vld=%b empty=%b ful=%b rdat=0x%02h", oDatVld, oEmpty, oFul, oRdDat);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wr, vecs[i].dat, vecs[i].rd);
      model_step($sformatf("vec%0d", i));
      @(posedge clk);
      @(negedge clk);
      check_status($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_dat);
      chk($sformatf("vec%0d.sb_occ", i), {30'd0, oDatVld}, {30'd0, occ_mask(sb_q.size())});
      $display("vec%0d: wr=%b dat=0x%02h rd=%b -> vld=%b rdat=0x%02h", i,
               vecs[i].wr, vecs[i].dat, vecs[i].rd, oDatVld, oRdDat);
    end

    // Mid-stream reset with two entries held and both requests active.
    rst = 1'b0;
    drive(1'b1, 8'h33, 1'b1);
    @(posedge clk);
    @(negedge clk);
    sb_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_status("midrst", 2'b00, 8'h00);
    $display("midrst: vld=%b empty=%b rdat=0x%02h", oDatVld, oEmpty, oRdDat);
    rst = 1'b1;
    drive(1'b1, 8'h11, 1'b0);
    model_step("postrst");
    @(posedge clk);
    @(negedge clk);
    check_status("postrst", 2'b01, 8'h11);
    $display("postrst: vld=%b rdat=0x%02h", oDatVld, oRdDat);

    // Random traffic against the queue scoreboard.
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      model_step($sformatf("rnd%0d", c));
      @(posedge clk);
      @(negedge clk);
      check_status($sformatf("rnd%0d", c), occ_mask(sb_q.size()),
                   (sb_q.size() > 0) ? sb_q[0] : 8'h00);
      $display("rnd%0d: wr=%b dat=0x%02h rd=%b -> vld=%b rdat=0x%02h", c,
               iWrEn, iWrDat, iRdEn, oDatVld, oRdDat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
